// File: rtl/id_ex_pipe_pkg.sv
// Shared NOP encodings, stall-vector bit indices and the ID/EX advance decision
// used by the ID/EX register and the stall controller.
package id_ex_pipe_pkg;

   localparam int DATA_W_DEF       = 32;
   localparam int REG_ADDR_W_DEF   = 5;
   localparam int ALUOP_W_DEF      = 8;
   localparam int ALUSEL_W_DEF     = 3;
   localparam int STALL_W_DEF      = 6;
   localparam int ID_STALL_BIT_DEF = 2;
   localparam int EX_STALL_BIT_DEF = 3;

   localparam logic [ALUOP_W_DEF-1:0]    EXE_NOP_OP  = '0;
   localparam logic [ALUSEL_W_DEF-1:0]   EXE_RES_NOP = '0;
   localparam logic [REG_ADDR_W_DEF-1:0] NOPRegAddr  = '0;
   localparam logic [DATA_W_DEF-1:0]     ZeroWord    = '0;

   typedef enum logic [1:0] {
      ACT_HOLD,
      ACT_LOAD,
      ACT_BUBBLE,
      ACT_FLUSH
   } pipe_act_e;

   // Flush beats every stall; !sid & sex is not a legal request and is held.
   function automatic pipe_act_e decode_act(input logic flush, input logic sid, input logic sex);
      if (flush)       return ACT_FLUSH;
      if (sid && !sex) return ACT_BUBBLE;
      if (!sid && !sex) return ACT_LOAD;
      return ACT_HOLD;
   endfunction

endpackage

// File: rtl/id_ex_pipe_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                  cnt <= '0;
      else if (clr)              cnt <= '0;
      else if (inc && cnt != '1) cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register: stall hold, bubble insertion, flush, valid bit,
// delay-slot feedback to ID and a saturating bubble counter.
module id_ex_pipe
   import id_ex_pipe_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int NUM_OPS      = 2,
   parameter int REG_ADDR_W   = 5,
   parameter int ALUOP_W      = 8,
   parameter int ALUSEL_W     = 3,
   parameter int STALL_W      = 6,
   parameter int ID_STALL_BIT = 2,
   parameter int EX_STALL_BIT = 3,
   parameter int CNT_W        = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic [STALL_W-1:0]        stall,
   input  logic                      cnt_clr,
   input  logic                      id_valid,
   input  logic [ALUOP_W-1:0]        id_aluop,
   input  logic [ALUSEL_W-1:0]       id_alusel,
   input  logic [NUM_OPS*DATA_W-1:0] id_regs,
   input  logic [REG_ADDR_W-1:0]     id_wd,
   input  logic                      id_wreg,
   input  logic [DATA_W-1:0]         id_link_addr,
   input  logic                      id_in_delayslot,
   input  logic                      id_next_in_delayslot,
   output logic                      ex_valid,
   output logic [ALUOP_W-1:0]        ex_aluop,
   output logic [ALUSEL_W-1:0]       ex_alusel,
   output logic [NUM_OPS*DATA_W-1:0] ex_regs,
   output logic [REG_ADDR_W-1:0]     ex_wd,
   output logic                      ex_wreg,
   output logic [DATA_W-1:0]         ex_link_addr,
   output logic                      ex_in_delayslot,
   output logic                      is_in_delayslot_o,
   output logic [CNT_W-1:0]          bubble_cnt
);

   localparam int PAY_W = 1 + ALUOP_W + ALUSEL_W + NUM_OPS*DATA_W + REG_ADDR_W + 1 + DATA_W + 1;

   logic [PAY_W-1:0] pay_q, pay_d, pay_id, pay_nop;
   logic             isds_q, isds_d;
   pipe_act_e        act;
   logic             stall_unused;

   assign act          = decode_act(flush, stall[ID_STALL_BIT], stall[EX_STALL_BIT]);
   assign stall_unused = ^stall;

   // wreg is qualified by valid here so EX never sees a write from a non-instruction.
   assign pay_id  = {id_valid, id_aluop, id_alusel, id_regs, id_wd, id_wreg & id_valid,
                     id_link_addr, id_in_delayslot};
   assign pay_nop = {1'b0, ALUOP_W'(EXE_NOP_OP), ALUSEL_W'(EXE_RES_NOP),
                     {NUM_OPS{DATA_W'(ZeroWord)}}, REG_ADDR_W'(NOPRegAddr), 1'b0,
                     DATA_W'(ZeroWord), 1'b0};

   always_comb begin
      pay_d  = pay_q;
      isds_d = isds_q;
      case (act)
         ACT_FLUSH: begin
            pay_d  = pay_nop;
            isds_d = 1'b0;
         end
         ACT_BUBBLE: pay_d = pay_nop;
         ACT_LOAD: begin
            pay_d  = pay_id;
            isds_d = id_next_in_delayslot;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pay_q  <= pay_nop;
         isds_q <= 1'b0;
      end else begin
         pay_q  <= pay_d;
         isds_q <= isds_d;
      end
   end

   assign {ex_valid, ex_aluop, ex_alusel, ex_regs, ex_wd, ex_wreg,
           ex_link_addr, ex_in_delayslot} = pay_q;
   assign is_in_delayslot_o = isds_q;

   sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk (clk),
      .rst (rst),
      .inc (act == ACT_BUBBLE),
      .clr (cnt_clr),
      .cnt (bubble_cnt)
   );

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (rst)
         assert (!(!stall[ID_STALL_BIT] && stall[EX_STALL_BIT]))
            else $error("id_ex_pipe: EX stalled while ID runs");
   end
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: directed table, randomized run against a rule-level model,
// asynchronous reset and 2-bit counter saturation.
module tb_id_ex_pipe;

   typedef struct packed {
      logic        valid;
      logic [7:0]  aluop;
      logic [2:0]  alusel;
      logic [63:0] regs;
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] link;
      logic        inds;
   } pay_t;

   typedef struct {
      logic        flush;
      logic        clr;
      logic [5:0]  stall;
      pay_t        in;
      logic        nextds;
      pay_t        exp;
      logic        exp_isds;
      logic [15:0] exp_cnt;
   } vec_t;

   logic clk = 1'b0;
   logic rst, flush, cnt_clr, nextds;
   logic [5:0] stall;
   pay_t din, dout;

   logic        ex_valid, ex_wreg, ex_in_delayslot, isds;
   logic [7:0]  ex_aluop;
   logic [2:0]  ex_alusel;
   logic [63:0] ex_regs;
   logic [4:0]  ex_wd;
   logic [31:0] ex_link_addr;
   logic [15:0] cnt;

   logic        b_valid, b_wreg, b_inds, b_isds;
   logic [7:0]  b_aluop;
   logic [2:0]  b_alusel;
   logic [63:0] b_regs;
   logic [4:0]  b_wd;
   logic [31:0] b_link;
   logic [1:0]  cnt2;

   always #5 clk = ~clk;

   id_ex_pipe dut (
      .clk(clk), .rst(rst), .flush(flush), .stall(stall), .cnt_clr(cnt_clr),
      .id_valid(din.valid), .id_aluop(din.aluop), .id_alusel(din.alusel),
      .id_regs(din.regs), .id_wd(din.wd), .id_wreg(din.wreg),
      .id_link_addr(din.link), .id_in_delayslot(din.inds),
      .id_next_in_delayslot(nextds),
      .ex_valid(ex_valid), .ex_aluop(ex_aluop), .ex_alusel(ex_alusel),
      .ex_regs(ex_regs), .ex_wd(ex_wd), .ex_wreg(ex_wreg),
      .ex_link_addr(ex_link_addr), .ex_in_delayslot(ex_in_delayslot),
      .is_in_delayslot_o(isds), .bubble_cnt(cnt)
   );

   id_ex_pipe #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .flush(flush), .stall(stall), .cnt_clr(cnt_clr),
      .id_valid(din.valid), .id_aluop(din.aluop), .id_alusel(din.alusel),
      .id_regs(din.regs), .id_wd(din.wd), .id_wreg(din.wreg),
      .id_link_addr(din.link), .id_in_delayslot(din.inds),
      .id_next_in_delayslot(nextds),
      .ex_valid(b_valid), .ex_aluop(b_aluop), .ex_alusel(b_alusel),
      .ex_regs(b_regs), .ex_wd(b_wd), .ex_wreg(b_wreg),
      .ex_link_addr(b_link), .ex_in_delayslot(b_inds),
      .is_in_delayslot_o(b_isds), .bubble_cnt(cnt2)
   );

   assign dout = '{valid:ex_valid, aluop:ex_aluop, alusel:ex_alusel, regs:ex_regs,
                   wd:ex_wd, wreg:ex_wreg, link:ex_link_addr, inds:ex_in_delayslot};

   int n_vec = 0;
   int n_bad = 0;

   pay_t m_pay;
   logic m_isds;
   int   m_cnt, m_cnt2;

   task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: the four priority rules applied to whole-instruction records.
   task automatic model_edge();
      logic sid, sex, bub;
      sid = stall[2];
      sex = stall[3];
      bub = 1'b0;
      if (flush) begin
         m_pay  = '0;
         m_isds = 1'b0;
      end else if (sid && !sex) begin
         m_pay = '0;
         bub   = 1'b1;
      end else if (!sid && !sex) begin
         m_pay      = din;
         m_pay.wreg = din.wreg & din.valid;
         m_isds     = nextds;
      end
      if (cnt_clr) begin
         m_cnt  = 0;
         m_cnt2 = 0;
      end else if (bub) begin
         if (m_cnt < 65535) m_cnt++;
         if (m_cnt2 < 3)    m_cnt2++;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic check_all(string tag);
      chk({tag, ".pay"},  128'(dout), 128'(m_pay));
      chk({tag, ".isds"}, 128'(isds), 128'(m_isds));
      chk({tag, ".cnt"},  128'(cnt),  128'(m_cnt));
      chk({tag, ".cnt2"}, 128'(cnt2), 128'(m_cnt2));
   endtask

   initial begin
      pay_t A, B, C, D, Dx, E, E2, N;
      vec_t tbl[13];
      logic [127:0] r;

      rst = 1'b0; flush = 1'b0; cnt_clr = 1'b0; stall = '0; din = '0; nextds = 1'b0;
      m_pay = '0; m_isds = 1'b0; m_cnt = 0; m_cnt2 = 0;
      repeat (2) @(negedge clk);
      check_all("reset");
      rst = 1'b1;

      N  = '0;
      A  = '{valid:1'b1, aluop:8'h21, alusel:3'd1, regs:{32'h5, 32'h7}, wd:5'd3, wreg:1'b1, link:32'h100, inds:1'b0};
      B  = '{valid:1'b1, aluop:8'h33, alusel:3'd2, regs:{32'hdead, 32'hbeef}, wd:5'd7, wreg:1'b1, link:32'h200, inds:1'b1};
      C  = '{valid:1'b1, aluop:8'hff, alusel:3'd7, regs:{32'h1111, 32'h2222}, wd:5'd31, wreg:1'b1, link:32'h300, inds:1'b1};
      D  = '{valid:1'b0, aluop:8'h44, alusel:3'd1, regs:{32'h9, 32'ha}, wd:5'd9, wreg:1'b1, link:32'h400, inds:1'b0};
      Dx = D; Dx.wreg = 1'b0;
      E  = '{valid:1'b1, aluop:8'h0c, alusel:3'd5, regs:{32'h12, 32'h34}, wd:5'd31, wreg:1'b1, link:32'h508, inds:1'b0};
      E2 = '{valid:1'b1, aluop:8'h25, alusel:3'd1, regs:{32'h56, 32'h78}, wd:5'd4, wreg:1'b0, link:32'h0, inds:1'b1};

      tbl[0]  = '{1'b0, 1'b0, 6'b000000, A,  1'b1, A,  1'b1, 16'd0};
      tbl[1]  = '{1'b0, 1'b0, 6'b000111, C,  1'b0, N,  1'b1, 16'd1};
      tbl[2]  = '{1'b0, 1'b0, 6'b000111, C,  1'b0, N,  1'b1, 16'd2};
      tbl[3]  = '{1'b0, 1'b0, 6'b000111, C,  1'b0, N,  1'b1, 16'd3};
      tbl[4]  = '{1'b0, 1'b0, 6'b000000, B,  1'b1, B,  1'b1, 16'd3};
      tbl[5]  = '{1'b0, 1'b0, 6'b001111, C,  1'b0, B,  1'b1, 16'd3};
      tbl[6]  = '{1'b0, 1'b0, 6'b001111, C,  1'b0, B,  1'b1, 16'd3};
      tbl[7]  = '{1'b1, 1'b0, 6'b001111, C,  1'b0, N,  1'b0, 16'd3};
      tbl[8]  = '{1'b0, 1'b0, 6'b000000, D,  1'b0, Dx, 1'b0, 16'd3};
      tbl[9]  = '{1'b0, 1'b1, 6'b000111, C,  1'b0, N,  1'b0, 16'd0};
      tbl[10] = '{1'b0, 1'b0, 6'b000000, E,  1'b1, E,  1'b1, 16'd0};
      tbl[11] = '{1'b0, 1'b0, 6'b000000, E2, 1'b0, E2, 1'b0, 16'd0};
      tbl[12] = '{1'b1, 1'b0, 6'b000111, C,  1'b0, N,  1'b0, 16'd0};

      for (int i = 0; i < 13; i++) begin
         flush = tbl[i].flush; cnt_clr = tbl[i].clr; stall = tbl[i].stall;
         din = tbl[i].in; nextds = tbl[i].nextds;
         cycle();
         chk($sformatf("tbl%0d.pay", i),  128'(dout), 128'(tbl[i].exp));
         chk($sformatf("tbl%0d.isds", i), 128'(isds), 128'(tbl[i].exp_isds));
         chk($sformatf("tbl%0d.cnt", i),  128'(cnt),  128'(tbl[i].exp_cnt));
         chk($sformatf("tbl%0d.cnt2", i), 128'(cnt2), 128'(m_cnt2));
      end

      for (int i = 0; i < 400; i++) begin
         int mode;
         mode  = $urandom_range(0, 3);
         stall = 6'($urandom);
         case (mode)
            0, 1: begin stall[2] = 1'b0; stall[3] = 1'b0; end
            2:    begin stall[2] = 1'b1; stall[3] = 1'b0; end
            default: begin stall[2] = 1'b1; stall[3] = 1'b1; end
         endcase
         flush   = ($urandom_range(0, 7) == 0);
         cnt_clr = ($urandom_range(0, 15) == 0);
         nextds  = 1'($urandom);
         r   = {$urandom, $urandom, $urandom, $urandom};
         din = r[$bits(pay_t)-1:0];
         cycle();
         check_all("rand");
      end

      flush = 1'b0; cnt_clr = 1'b0; stall = '0; din = A; nextds = 1'b1;
      cycle();
      check_all("pre_rst");
      #2 rst = 1'b0;
      #1;
      m_pay = '0; m_isds = 1'b0; m_cnt = 0; m_cnt2 = 0;
      check_all("async_rst");
      @(negedge clk);
      rst = 1'b1; din = B; nextds = 1'b0;
      cycle();
      check_all("post_rst");

      stall = 6'b000111; din = C;
      repeat (5) begin
         cycle();
         check_all("sat");
      end
      chk("cnt2_saturated", 128'(cnt2), 128'd3);
      cnt_clr = 1'b1;
      cycle();
      chk("cnt2_clr_wins", 128'(cnt2), 128'd0);
      check_all("clr");
      cnt_clr = 1'b0; stall = '0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
